bist_datapath: RTL and testbench

BIST pattern datapath driven by the BIST control path's one-hot enables (`ring_counter_enable`, `johnson_counter_enable`, `lfsr_enable`). It generates the selected test pattern on the LED bus, advancing one step per prescaled tick. It also flags illegal enable combinations. It sits between the BIST control path and the board LED pins.

---
 rtl/bist_datapath.sv | 112 +++++++++++
 tb/tb_bist_datapath.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_datapath.sv
// BIST pattern datapath: decodes the one-hot BIST enables into a mode,
// prescales the clock into pattern steps and drives ring / Johnson / LFSR
// patterns onto the LED bus. Illegal (multi-hot) enables raise enable_error.
// Optional build macro: BIST_MISR_EN adds a MISR signature over every new pattern.
module bist_datapath #(
  parameter int               WIDTH     = 8,
  parameter int               TICK_DIV  = 25_000_000,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ring_counter_enable,
  input  logic             johnson_counter_enable,
  input  logic             lfsr_enable,
  output logic [WIDTH-1:0] led,
  output logic             pattern_valid,
`ifdef BIST_MISR_EN
  output logic [WIDTH-1:0] signature,
`endif
  output logic             enable_error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RING    = 3'd1;
  localparam logic [2:0] JOHNSON = 3'd2;
  localparam logic [2:0] LFSR    = 3'd3;
  localparam logic [2:0] ERROR   = 3'd4;

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [2:0]       mode, mode_next;
  logic [CNT_W-1:0] cnt;
  logic             entry, run, tick;
  logic [WIDTH-1:0] seed, led_step;

  // Decode the enables into the requested mode; multi-hot is an error
  always_comb begin
    mode_next = ERROR;
    case ({ring_counter_enable, johnson_counter_enable, lfsr_enable})
      3'b000:  mode_next = IDLE;
      3'b100:  mode_next = RING;
      3'b010:  mode_next = JOHNSON;
      3'b001:  mode_next = LFSR;
      default: mode_next = ERROR;
    endcase
  end

  // A mode change always wins over a coincident tick
  assign entry = (mode_next != mode);
  assign run   = (mode == RING) || (mode == JOHNSON) || (mode == LFSR);
  assign tick  = run && !entry && (cnt == CNT_LAST);

  // Seed for the mode being entered and next step of the current pattern
  always_comb begin
    seed = '0;
    case (mode_next)
      RING:    seed = WIDTH'(1);
      LFSR:    seed = LFSR_SEED;
      default: seed = '0;
    endcase
    led_step = led;
    case (mode)
      RING:    led_step = {led[WIDTH-2:0], led[WIDTH-1]};
      JOHNSON: led_step = {led[WIDTH-2:0], ~led[WIDTH-1]};
      LFSR:    led_step = (led >> 1) ^ (led[0] ? LFSR_TAPS : '0);
      default: led_step = led;
    endcase
  end

  // Mode, prescaler, pattern and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode          <= IDLE;
      cnt           <= '0;
      led           <= '0;
      pattern_valid <= 1'b0;
      enable_error  <= 1'b0;
    end else begin
      mode          <= mode_next;
      enable_error  <= (mode_next == ERROR);
      pattern_valid <= tick;
      if (entry) begin
        cnt <= '0;
        // ERROR keeps whatever was on the LEDs so the failing pattern stays visible
        if (mode_next != ERROR) led <= seed;
      end else if (run) begin
        if (tick) begin
          cnt <= '0;
          led <= led_step;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef BIST_MISR_EN
  // Signature compactor: Galois shift of the old signature folded with the new pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= '0;
    end else if (entry) begin
      signature <= '0;
    end else if (tick) begin
      signature <= ((signature >> 1) ^ (signature[0] ? LFSR_TAPS : '0)) ^ led_step;
    end
  end
`endif

endmodule

// File: tb/tb_bist_datapath.sv
// Self-checking bench for bist_datapath (WIDTH=8, TICK_DIV=4).
// Expected values come from a mode/elapsed-cycle model: the pattern is a
// closed-form function of how many steps have elapsed since mode entry.
module tb_bist_datapath;
  localparam int W  = 8;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ren = 1'b0, jen = 1'b0, len = 1'b0;
  logic [W-1:0] led;
  logic         pattern_valid, enable_error;
`ifdef BIST_MISR_EN
  logic [W-1:0] signature;
`endif

  bist_datapath #(.WIDTH(W), .TICK_DIV(TD), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ring_counter_enable    (ren),
    .johnson_counter_enable (jen),
    .lfsr_enable            (len),
    .led                    (led),
    .pattern_valid          (pattern_valid),
`ifdef BIST_MISR_EN
    .signature              (signature),
`endif
    .enable_error           (enable_error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: 0 idle, 1 ring, 2 johnson, 3 lfsr, 4 error
  int           m_mode = 0;
  int           m_n    = 0;
  logic [W-1:0] e_led  = '0;
  logic         e_pv   = 1'b0;
  logic         e_err  = 1'b0;

  function automatic int dec(input logic r, input logic j, input logic l);
    int c;
    c = int'(r) + int'(j) + int'(l);
    if (c == 0) return 0;
    if (c > 1)  return 4;
    return r ? 1 : (j ? 2 : 3);
  endfunction

  // Pattern value after adv steps from the seed of mode md
  function automatic logic [W-1:0] pat(input int md, input int adv);
    logic [W-1:0] p;
    int k;
    p = '0;
    case (md)
      1: p = W'(1 << (adv % W));
      2: begin
        k = adv % (2 * W);
        if (k <= W) p = W'((1 << k) - 1);
        else        p = W'(9'h0FF << (k - W));
      end
      3: begin
        p = 8'h01;
        for (int i = 0; i < adv % 255; i++) p = (p >> 1) ^ (p[0] ? 8'hB8 : 8'h00);
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Drive one cycle of stimulus and advance the model to match
  task automatic cyc(input logic r, input logic j, input logic l);
    int dm;
    ren = r; jen = j; len = l;
    @(posedge clk); #1;
    dm = dec(r, j, l);
    if (rst) begin
      m_mode = 0; m_n = 0; e_led = '0; e_pv = 1'b0; e_err = 1'b0;
    end else if (dm != m_mode) begin
      m_mode = dm; m_n = 0; e_pv = 1'b0; e_err = (dm == 4);
      if (dm != 4) e_led = pat(dm, 0);
    end else begin
      m_n++;
      e_err = (dm == 4);
      if (dm >= 1 && dm <= 3) begin
        e_pv  = (m_n % TD == 0);
        e_led = pat(dm, m_n / TD);
      end else begin
        e_pv = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    total++; if (led !== 8'h00) $display("FAIL reset_led got=%h exp=00", led); else passed++;
    total++; if (pattern_valid !== 1'b0) $display("FAIL reset_pv got=%b exp=0", pattern_valid); else passed++;
    total++; if (enable_error !== 1'b0) $display("FAIL reset_err got=%b exp=0", enable_error); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_ring();
    int last_pv, gaps_bad;
    last_pv = -1; gaps_bad = 0;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    total++; if (led !== 8'h01) $display("FAIL ring_seed got=%h exp=01", led); else passed++;
    for (int c = 1; c <= 9 * TD; c++) begin
      cyc(1, 0, 0);
      total++;
      if (led !== W'(1 << ((c / TD) % W)) || pattern_valid !== (c % TD == 0))
        $display("FAIL ring_step c=%0d got=%h/%b exp=%h/%b", c, led, pattern_valid,
                 W'(1 << ((c / TD) % W)), (c % TD == 0));
      else passed++;
      if (pattern_valid) begin
        if (last_pv >= 0 && c - last_pv != TD) gaps_bad++;
        last_pv = c;
      end
    end
    total++; if (gaps_bad != 0 || last_pv < 0) $display("FAIL ring_pv_spacing bad=%0d last=%0d exp_gap=%0d", gaps_bad, last_pv, TD); else passed++;
  endtask

  task automatic test_johnson();
    logic [W-1:0] jt [0:16];
    jt = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
           8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int c = 0; c <= 16 * TD; c++) begin
      if (c > 0) cyc(0, 1, 0);
      total++;
      if (led !== jt[c / TD]) $display("FAIL johnson_step c=%0d got=%h exp=%h", c, led, jt[c / TD]);
      else passed++;
    end
  endtask

  task automatic test_lfsr();
    logic [W-1:0] lt [0:5];
    lt = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    for (int c = 0; c <= 255 * TD; c++) begin
      if (c > 0) cyc(0, 0, 1);
      if (c % TD == 0 && c / TD < 6) begin
        total++;
        if (led !== lt[c / TD]) $display("FAIL lfsr_head k=%0d got=%h exp=%h", c / TD, led, lt[c / TD]);
        else passed++;
      end
      if (c % TD == 1) begin
        total++;
        if (led !== e_led || pattern_valid !== e_pv)
          $display("FAIL lfsr_step c=%0d got=%h/%b exp=%h/%b", c, led, pattern_valid, e_led, e_pv);
        else passed++;
      end
    end
    total++; if (led !== 8'h01) $display("FAIL lfsr_period got=%h exp=01", led); else passed++;
  endtask

  task automatic test_error();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int c = 0; c < 2 * TD; c++) cyc(1, 0, 0);
    total++; if (led !== 8'h04) $display("FAIL err_pre got=%h exp=04", led); else passed++;
    for (int c = 0; c < 2 * TD; c++) begin
      cyc(1, 0, 1);
      total++;
      if (enable_error !== 1'b1 || led !== 8'h04 || pattern_valid !== 1'b0)
        $display("FAIL err_hold c=%0d got=%b/%h/%b exp=1/04/0", c, enable_error, led, pattern_valid);
      else passed++;
    end
    cyc(0, 0, 1);
    total++;
    if (enable_error !== 1'b0 || led !== 8'h01)
      $display("FAIL err_exit got=%b/%h exp=0/01", enable_error, led);
    else passed++;
  endtask

  task automatic test_switch_on_tick();
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int c = 0; c < 2 * TD - 1; c++) cyc(0, 1, 0);
    cyc(1, 0, 0);
    total++;
    if (led !== 8'h01 || pattern_valid !== 1'b0)
      $display("FAIL switch_tick got=%h/%b exp=01/0", led, pattern_valid);
    else passed++;
    cyc(0, 0, 0);
    total++; if (led !== 8'h00 || pattern_valid !== 1'b0) $display("FAIL idle_led got=%h/%b exp=00/0", led, pattern_valid); else passed++;
  endtask

  task automatic test_midreset();
    cyc(0, 0, 1);
    for (int c = 0; c < TD + 2; c++) cyc(0, 0, 1);
    rst = 1'b1;
    cyc(0, 0, 1);
    total++;
    if (led !== 8'h00 || pattern_valid !== 1'b0 || enable_error !== 1'b0)
      $display("FAIL midreset got=%h/%b/%b exp=00/0/0", led, pattern_valid, enable_error);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] en;
    int len_run;
    for (int b = 0; b < 60; b++) begin
      en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) en = 3'b001 << $urandom_range(0, 2);
      len_run = $urandom_range(1, 14);
      for (int c = 0; c < len_run; c++) begin
        cyc(en[2], en[1], en[0]);
        total++;
        if (led !== e_led || pattern_valid !== e_pv || enable_error !== e_err)
          $display("FAIL random b=%0d c=%0d en=%b got=%h/%b/%b exp=%h/%b/%b", b, c, en,
                   led, pattern_valid, enable_error, e_led, e_pv, e_err);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_johnson();
    test_lfsr();
    test_error();
    test_switch_on_tick();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
